// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment display.
package seven_seg_pkg;

  // Index of one of the four display digits (0 = rightmost).
  typedef logic [1:0] digit_t;

  // Active-low anode patterns, one per digit, plus the all-off pattern.
  localparam logic [3:0] ANODE_D0  = 4'b1110;
  localparam logic [3:0] ANODE_D1  = 4'b1101;
  localparam logic [3:0] ANODE_D2  = 4'b1011;
  localparam logic [3:0] ANODE_D3  = 4'b0111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Active-low segment encodings {g,f,e,d,c,b,a}, indexed by hex nibble.
  localparam logic [0:15][6:0] SEG_TABLE = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Maps a digit index to its anode enable pattern.
  function automatic logic [3:0] anode_pattern(input digit_t d);
    case (d)
      2'd0:    return ANODE_D0;
      2'd1:    return ANODE_D1;
      2'd2:    return ANODE_D2;
      2'd3:    return ANODE_D3;
      default: return ANODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup; the table already holds active-low encodings.
  always_comb seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// Four-digit multiplexed seven-segment controller with a frame-aligned
// double-buffered hex value, leading-zero suppression and blanking.
module seven_seg_display_ctrl
  import seven_seg_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank,
  input  logic        lzs_en,
  output logic [3:0]  anode,
  output logic [6:0]  cathode,
  output logic        dp,
  output logic [1:0]  digit_sel,
  output logic        frame_done,
  output logic        pending
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  digit_t           digit_reg;
  logic             tick;
  logic             wrap;

  logic [15:0]      act_val_reg;
  logic [3:0]       act_dp_reg;
  logic [15:0]      pend_val_reg;
  logic [3:0]       pend_dp_reg;
  logic             pending_reg;
  logic             frame_done_reg;

  logic [3:0]       anode_reg;
  logic [6:0]       cathode_reg;
  logic             dp_reg;

  logic [3:0]       lead_zero;
  logic [3:0]       cur_nibble;
  logic [6:0]       cur_seg;
  logic [3:0]       anode_next;

  assign tick = (cnt_reg == TICK_LAST);
  assign wrap = tick && (digit_reg == 2'd3);

  // A digit is a leading zero when it and every digit to its left are zero
  // with no decimal point requested; digit 0 always stays visible.
  assign lead_zero[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lead_zero
      assign lead_zero[gi] = (act_val_reg[15:4*gi] == '0) && (act_dp_reg[3:gi] == '0);
    end
  endgenerate

  assign cur_nibble = act_val_reg[{digit_reg, 2'b00} +: 4];

  hex_to_seven_seg u_decode (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Anode for the scanned digit, forced off by blanking or suppression.
  always_comb begin
    anode_next = anode_pattern(digit_reg);
    if (blank || (lzs_en && lead_zero[digit_reg])) begin
      anode_next = ANODE_OFF;
    end
  end

  // Prescaler and digit scan counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      digit_reg <= 2'd0;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + CNT_W'(1);
      if (tick) begin
        digit_reg <= digit_reg + 2'd1;
      end
    end
  end

  // Double buffer: loads park in the pending buffer and commit at frame wrap;
  // a load landing on the wrap itself bypasses straight to the active buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act_val_reg  <= '0;
      act_dp_reg   <= '0;
      pend_val_reg <= '0;
      pend_dp_reg  <= '0;
      pending_reg  <= 1'b0;
    end else if (load && wrap) begin
      act_val_reg <= value;
      act_dp_reg  <= dp_in;
      pending_reg <= 1'b0;
    end else if (wrap && pending_reg) begin
      act_val_reg <= pend_val_reg;
      act_dp_reg  <= pend_dp_reg;
      pending_reg <= 1'b0;
    end else if (load) begin
      pend_val_reg <= value;
      pend_dp_reg  <= dp_in;
      pending_reg  <= 1'b1;
    end
  end

  // Registered pin drivers and frame pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anode_reg      <= ANODE_OFF;
      cathode_reg    <= 7'b1111111;
      dp_reg         <= 1'b1;
      frame_done_reg <= 1'b0;
    end else begin
      anode_reg      <= anode_next;
      cathode_reg    <= cur_seg;
      dp_reg         <= ~act_dp_reg[digit_reg];
      frame_done_reg <= wrap;
    end
  end

  assign anode      = anode_reg;
  assign cathode    = cathode_reg;
  assign dp         = dp_reg;
  assign digit_sel  = digit_reg;
  assign frame_done = frame_done_reg;
  assign pending    = pending_reg;

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Scoreboard bench for seven_seg_display_ctrl with a cycle-count based model.
module tb_seven_seg_display_ctrl;

  localparam int TD    = 4;
  localparam int FRAME = 4 * TD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic        lzs_en = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_done;
  logic        pending;

  int vectors = 0;
  int miscompares = 0;

  seven_seg_display_ctrl #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clock      (clk),
    .reset      (rst),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .blank      (blank),
    .lzs_en     (lzs_en),
    .anode      (anode),
    .cathode    (cathode),
    .dp         (dp),
    .digit_sel  (digit_sel),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] cat;
    logic       dp;
    logic [1:0] dsel;
    logic       fd;
    logic       pend;
  } exp_t;

  typedef struct packed {
    int          n;    // cycles elapsed since reset release
    logic [15:0] av;
    logic [3:0]  ad;
    logic [15:0] pv;
    logic [3:0]  pd;
    logic        p;
  } mstate_t;

  localparam exp_t RESET_EXP = '{an: 4'b1111, cat: 7'b1111111, dp: 1'b1,
                                 dsel: 2'd0, fd: 1'b0, pend: 1'b0};

  exp_t    q[$];
  mstate_t m = '0;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic bit is_wrap(input int n);
    return (n % FRAME) == FRAME - 1;
  endfunction

  function automatic mstate_t next_state(input mstate_t s, input logic ld,
                                         input logic [15:0] v, input logic [3:0] d);
    mstate_t r = s;
    if (ld && is_wrap(s.n)) begin
      r.av = v; r.ad = d; r.p = 1'b0;
    end else if (is_wrap(s.n) && s.p) begin
      r.av = s.pv; r.ad = s.pd; r.p = 1'b0;
    end else if (ld) begin
      r.pv = v; r.pd = d; r.p = 1'b1;
    end
    r.n = s.n + 1;
    return r;
  endfunction

  function automatic exp_t outputs(input mstate_t pre, input mstate_t post,
                                   input logic blk, input logic lz);
    exp_t e;
    int   d = (pre.n / TD) % 4;
    bit   sup = lz && d > 0 && ((pre.av >> (4 * d)) == 0) && ((pre.ad >> d) == 0);
    e.an   = (blk || sup) ? 4'b1111 : (4'b1111 ^ (4'b0001 << d));
    e.cat  = seg_of(4'((pre.av >> (4 * d)) & 16'hF));
    e.dp   = ~pre.ad[d];
    e.dsel = 2'((post.n / TD) % 4);
    e.fd   = is_wrap(pre.n);
    e.pend = post.p;
    return e;
  endfunction

  // Reference model: predicts the outputs following every edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '0;
      q.delete();
      q.push_back(RESET_EXP);
    end else begin
      m <= next_state(m, load, value, dp_in);
      q.push_back(outputs(m, next_state(m, load, value, dp_in), blank, lzs_en));
    end
  end

  // Monitor: one comparison per cycle against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (anode !== e.an || cathode !== e.cat || dp !== e.dp || digit_sel !== e.dsel ||
          frame_done !== e.fd || pending !== e.pend) begin
        miscompares++;
        $display("FAIL vec%0d t=%0t: anode %b/%b cathode %b/%b dp %b/%b sel %0d/%0d fd %b/%b pend %b/%b (got/exp)",
                 vectors, $time, anode, e.an, cathode, e.cat, dp, e.dp, digit_sel, e.dsel,
                 frame_done, e.fd, pending, e.pend);
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Waits until the next edge falls at frame phase ph, bounded to two frames.
  task automatic wait_phase(input int ph);
    int k = 0;
    while ((m.n % FRAME) != ph && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    if ((m.n % FRAME) != ph) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_phase: phase %0d required, %0d reached", ph, m.n % FRAME);
    end
  endtask

  // Asynchronous reset shortly after an edge, with an immediate output check.
  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (anode !== 4'b1111 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: anode %b pending %b, required 1111 0", anode, pending);
    end
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    cycles(3);
    rst = 1'b0;

    // Free-running scan of the zero value.
    cycles(40);

    // Load during digit 1, committed at the next wrap.
    wait_phase(5);
    pulse_load(16'h12AF, 4'b0000);
    cycles(40);

    // Last write wins within a frame.
    wait_phase(1);
    pulse_load(16'h1111, 4'b0000);
    wait_phase(6);
    pulse_load(16'h2222, 4'b0000);
    cycles(36);

    // Load on the exact wrap cycle with suppression enabled.
    lzs_en = 1'b1;
    wait_phase(FRAME - 1);
    pulse_load(16'h0007, 4'b0000);
    cycles(32);

    // Decimal point keeps digit 2 from being suppressed.
    pulse_load(16'h0050, 4'b0100);
    cycles(40);

    // Blanking over a frame while a value commits underneath.
    lzs_en = 1'b0;
    blank = 1'b1;
    wait_phase(3);
    pulse_load(16'h0ABC, 4'b1001);
    cycles(36);
    blank = 1'b0;

    // Reset mid-frame with a load outstanding.
    wait_phase(2);
    pulse_load(16'hBEEF, 4'b0010);
    async_reset();
    cycles(24);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: value = 16'($urandom) & 16'h000F;
        1: value = 16'($urandom) & 16'h00FF;
        2: value = 16'($urandom) & 16'h0FFF;
        default: value = 16'($urandom);
      endcase
      dp_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 49) == 0) lzs_en = ~lzs_en;
      if ($urandom_range(0, 79) == 0) blank = ~blank;
      if ($urandom_range(0, 499) == 0) begin
        load = 1'b0;
        async_reset();
      end
    end
    load = 1'b0;
    cycles(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_seg_display_ctrl.md
Name: seven_seg_display_ctrl

Overview:
- Sequences the 4-digit multiplexed seven-segment display from a single system clock.
- Generates the per-digit refresh tick internally, rotates the active-low anode, and drives active-low cathodes and decimal point for the selected digit.
- Holds a double-buffered 16-bit hex value, so a new value is applied only at a frame boundary and the display never tears mid-scan.
- Sits between the math/datapath result registers and the board display pins.

Parameters:
- TICK_DIV, 100000: clock cycles per digit slot; minimum 2. At 100 MHz this gives a 1 kHz digit rate and a 250 Hz frame rate.
- CNT_W, 17: prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clock  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- value  in  16  hex value to display; nibble 0 is the rightmost digit.
- dp_in  in  4  decimal-point request per digit, active-high; captured with value.
- load  in  1  single-cycle strobe that captures value and dp_in into the pending buffer.
- blank  in  1  level; while high, all anodes are off (1111). Scanning continues underneath.
- lzs_en  in  1  level; enables leading-zero suppression.
- anode  out  4  active-low digit enable; digit 0 = 1110, 1 = 1101, 2 = 1011, 3 = 0111.
- cathode  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- digit_sel  out  2  index of the digit currently scanned.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.
- pending  out  1  high while a loaded value is waiting for the frame boundary.

Behaviour:
- Reset values: prescaler 0, digit_sel 0, active buffer 0, pending buffer 0, pending 0, frame_done 0, anode 1111, cathode 1111111, dp 1.
- Prescaler: counts 0..TICK_DIV-1 and then wraps. tick is high when count == TICK_DIV-1.
- Digit advance: on tick, digit_sel increments modulo 4 (0,1,2,3,0).
- wrap condition: tick && digit_sel == 3. frame_done is registered and is high for the one cycle after the wrap edge.
- load with no wrap in the same cycle: value/dp_in are written to the pending buffer and pending is set. A later load before the commit overwrites the buffer (last write wins).
- Commit: on wrap with pending == 1, the pending buffer is copied into the active buffer and pending clears.
- load coincident with wrap: the incoming value/dp_in go directly into the active buffer and pending clears. Any older pending value is discarded.
- Outputs: anode, cathode and dp are registered, one cycle after digit_sel or the active buffer changes.
  - anode = pattern(digit_sel), unless blank or the digit is suppressed, in which case anode = 1111.
  - cathode = hex decode of the active nibble at digit_sel.
  - dp = ~active_dp[digit_sel].
- Hex decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero suppression (lzs_en = 1): digit k (k = 3..1) is suppressed when nibbles k..3 are all zero and no dp bit in k..3 is set. Digit 0 is never suppressed.
- blank: affects the anode only. Prescaler, digit_sel, commit and frame_done are unaffected.
- Reset asserted mid-frame: takes effect immediately (asynchronous). Any pending load is lost. After release, digit 0 resumes with a fresh TICK_DIV count.

Decomposition:
- seven_seg_pkg holds:
  - the 16-entry segment-encoding constant table;
  - the four anode pattern constants and the all-off constant ANODE_OFF = 1111;
  - the 2-bit digit index typedef.
- Sub-module hex_to_seven_seg: purely combinational 4-bit to 7-bit active-low decoder.

Test Plan (TICK_DIV = 4 in simulation):
- Reset then release, no load -> anode is 1111 during reset; then 1110, 1101, 1011, 0111 at 4-cycle steps with cathode 1000000. frame_done pulses every 16 cycles.
- load value=16'h12AF at digit 1 -> pending=1; display keeps the old digits until the wrap. After frame_done: digit 0 cathode 0001110, digit 3 cathode 1111001, pending=0.
- Two loads 16'h1111 then 16'h2222 within one frame -> only 2222 is displayed; 1111 is never shown.
- load 16'h0007 on the exact wrap cycle -> the next frame shows 0007 immediately and pending stays 0. With lzs_en=1: anodes for digits 3..1 stay 1111, digit 0 shows 1111000.
- lzs_en=1, value 16'h0050, dp_in=4'b0100 -> digit 3 suppressed. Digits 2, 1 and 0 are shown; digit 2 has dp=0.
- blank=1 for a full frame -> anode 1111 throughout; frame_done still pulses and a pending value still commits. Asserting reset mid-frame clears pending and anode returns to 1111 asynchronously.
